// File: rtl/spi_frame_pkg.sv
// Shared types and helpers for the SPI slave frame engine.
package spi_frame_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } state_t;

  localparam int unsigned ST_ROOM    = 0;
  localparam int unsigned ST_PAYLOAD = 1;
  localparam int unsigned ST_OVF     = 2;
  localparam int unsigned ST_RSVD    = 3;
  localparam int unsigned ST_CNT_LSB = 4;

  // Sampling happens on the rising SCK edge exactly when CPOL equals CPHA.
  function automatic bit sample_on_rise(input bit cpol, input bit cpha);
    return cpol == cpha;
  endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// Synchronous RX FIFO with occupancy count; a pop on a full FIFO frees room for a same-cycle push.
module spi_rx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/spi_slave_frame.sv
// Oversampled SPI slave frame engine: synchronised pins, TX pending register with status header, RX FIFO.
module spi_slave_frame
  import spi_frame_pkg::*;
#(
  parameter int FRAME_BITS  = 32,
  parameter int STATUS_BITS = 8,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter bit MSB_FIRST   = 1'b0,
  parameter int RX_DEPTH    = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            SPI_SCK,
  input  logic                            SPI_SS,
  input  logic                            SPI_MOSI,
  output logic                            SPI_MISO,
  input  logic [FRAME_BITS-STATUS_BITS-1:0] tx_data,
  input  logic                            tx_valid,
  output logic                            tx_ready,
  output logic [FRAME_BITS-1:0]           rx_data,
  output logic                            rx_valid,
  input  logic                            rx_ready,
  output logic                            rx_overflow,
  output logic                            frame_abort,
  input  logic                            ovf_clr
);
  localparam int PAYLOAD_BITS = FRAME_BITS - STATUS_BITS;
  localparam int CNT_W        = $clog2(RX_DEPTH) + 1;
  localparam int BIT_W        = $clog2(FRAME_BITS + 1);
  localparam bit SAMPLE_RISE  = sample_on_rise(CPOL, CPHA);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS);

  state_t                  state;
  logic [2:0]              sck_p, ss_p;
  logic [1:0]              mosi_p;
  logic [BIT_W-1:0]        bit_cnt;
  logic [FRAME_BITS-1:0]   rx_sh, tx_sh, push_word;
  logic [PAYLOAD_BITS-1:0] pend;
  logic                    pend_full, push_pend;

  logic                    sck_rise, sck_fall, sample_ev, shift_ev, ss_hi, mosi_s;
  logic [3:0]              flags;
  logic [STATUS_BITS-1:0]  status;
  logic [PAYLOAD_BITS-1:0] payload;
  logic [FRAME_BITS-1:0]   word, word_adv, tx_adv, rx_next;
  logic                    word_first, tx_first;
  logic [CNT_W-1:0]        fifo_count;
  logic                    fifo_full, fifo_empty, drop;

  assign sck_rise  = sck_p[1] & ~sck_p[2];
  assign sck_fall  = ~sck_p[1] & sck_p[2];
  assign sample_ev = SAMPLE_RISE ? sck_rise : sck_fall;
  assign shift_ev  = SAMPLE_RISE ? sck_fall : sck_rise;
  assign ss_hi     = ss_p[1];
  assign mosi_s    = mosi_p[1];

  assign tx_ready  = ~pend_full;
  assign rx_valid  = ~fifo_empty;
  assign drop      = push_pend & fifo_full & ~(rx_ready & ~fifo_empty);

  always_comb begin
    flags             = '0;
    flags[ST_ROOM]    = ~fifo_full;
    flags[ST_PAYLOAD] = pend_full;
    flags[ST_OVF]     = rx_overflow;
    status            = STATUS_BITS'({fifo_count, flags});
    payload           = pend_full ? pend : '0;
    // Status always leads on the wire, so its placement in the word follows the bit order.
    word       = MSB_FIRST ? {status, payload} : {payload, status};
    word_first = MSB_FIRST ? word[FRAME_BITS-1] : word[0];
    word_adv   = MSB_FIRST ? {word[FRAME_BITS-2:0], 1'b0} : {1'b0, word[FRAME_BITS-1:1]};
    tx_first   = MSB_FIRST ? tx_sh[FRAME_BITS-1] : tx_sh[0];
    tx_adv     = MSB_FIRST ? {tx_sh[FRAME_BITS-2:0], 1'b0} : {1'b0, tx_sh[FRAME_BITS-1:1]};
    rx_next    = MSB_FIRST ? {rx_sh[FRAME_BITS-2:0], mosi_s} : {mosi_s, rx_sh[FRAME_BITS-1:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_p       <= {3{CPOL}};
      ss_p        <= '1;
      mosi_p      <= '0;
      state       <= IDLE;
      bit_cnt     <= '0;
      rx_sh       <= '0;
      tx_sh       <= '0;
      push_word   <= '0;
      push_pend   <= 1'b0;
      pend        <= '0;
      pend_full   <= 1'b0;
      SPI_MISO    <= 1'b1;
      rx_overflow <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      sck_p       <= {sck_p[1:0], SPI_SCK};
      ss_p        <= {ss_p[1:0], SPI_SS};
      mosi_p      <= {mosi_p[0], SPI_MOSI};
      frame_abort <= 1'b0;
      push_pend   <= 1'b0;

      if (tx_valid && !pend_full) begin
        pend      <= tx_data;
        pend_full <= 1'b1;
      end

      if (drop)         rx_overflow <= 1'b1;
      else if (ovf_clr) rx_overflow <= 1'b0;

      case (state)
        IDLE: begin
          SPI_MISO <= 1'b1;
          bit_cnt  <= '0;
          if (!ss_hi) state <= LOAD;
        end
        LOAD: begin
          bit_cnt <= '0;
          if (ss_hi) begin
            SPI_MISO <= 1'b1;
            state    <= IDLE;
          end else begin
            if (pend_full) pend_full <= 1'b0;
            if (!CPHA) begin
              SPI_MISO <= word_first;
              tx_sh    <= word_adv;
            end else begin
              tx_sh    <= word;
            end
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (ss_hi) begin
            if (bit_cnt != '0 && bit_cnt != LAST_BIT) frame_abort <= 1'b1;
            SPI_MISO <= 1'b1;
            bit_cnt  <= '0;
            state    <= IDLE;
          end else if (bit_cnt == LAST_BIT) begin
            state <= LOAD;
          end else begin
            if (sample_ev) begin
              rx_sh   <= rx_next;
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT - 1'b1) begin
                push_pend <= 1'b1;
                push_word <= rx_next;
              end
            end
            // With CPHA=0 the trailing edge right after a frame boundary would skip the bit LOAD already drove.
            if (shift_ev && (CPHA || bit_cnt != '0)) begin
              SPI_MISO <= tx_first;
              tx_sh    <= tx_adv;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  spi_rx_fifo #(
    .WIDTH(FRAME_BITS),
    .DEPTH(RX_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_pend),
    .push_data (push_word),
    .pop       (rx_ready),
    .head      (rx_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_spi_slave_frame.sv
// Directed bench: one default-config slave plus four 16-bit MSB-first slaves, one per SPI mode.
module tb_spi_slave_frame;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [4:0]  sck, ss, mosi, miso;

  logic [3:0][15:0] rxd_m;
  logic [3:0]       rxv_m, rxr_m, ovf_m, clr_m, abt_m, txr_m;

  logic [23:0] txd_a;
  logic        txv_a, txr_a, rxv_a, rxr_a, ovf_a, abt_a, clr_a;
  logic [31:0] rxd_a;

  int n_checks = 0;
  int n_pass   = 0;
  int abort_cnt = 0;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_mode
      spi_slave_frame #(
        .FRAME_BITS  (16),
        .STATUS_BITS (8),
        .CPOL        (bit'(g / 2)),
        .CPHA        (bit'(g % 2)),
        .MSB_FIRST   (1'b1),
        .RX_DEPTH    (2)
      ) dut (
        .clk         (clk),
        .reset       (reset),
        .SPI_SCK     (sck[g]),
        .SPI_SS      (ss[g]),
        .SPI_MOSI    (mosi[g]),
        .SPI_MISO    (miso[g]),
        .tx_data     (8'h00),
        .tx_valid    (1'b0),
        .tx_ready    (txr_m[g]),
        .rx_data     (rxd_m[g]),
        .rx_valid    (rxv_m[g]),
        .rx_ready    (rxr_m[g]),
        .rx_overflow (ovf_m[g]),
        .frame_abort (abt_m[g]),
        .ovf_clr     (clr_m[g])
      );
    end
  endgenerate

  spi_slave_frame #(
    .FRAME_BITS  (32),
    .STATUS_BITS (8),
    .CPOL        (1'b0),
    .CPHA        (1'b0),
    .MSB_FIRST   (1'b0),
    .RX_DEPTH    (4)
  ) dut_a (
    .clk         (clk),
    .reset       (reset),
    .SPI_SCK     (sck[4]),
    .SPI_SS      (ss[4]),
    .SPI_MOSI    (mosi[4]),
    .SPI_MISO    (miso[4]),
    .tx_data     (txd_a),
    .tx_valid    (txv_a),
    .tx_ready    (txr_a),
    .rx_data     (rxd_a),
    .rx_valid    (rxv_a),
    .rx_ready    (rxr_a),
    .rx_overflow (ovf_a),
    .frame_abort (abt_a),
    .ovf_clr     (clr_a)
  );

  always @(negedge clk) if (abt_a === 1'b1) abort_cnt <= abort_cnt + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic bit cpol_of(input int ch);
    return (ch < 4) ? bit'(ch / 2) : 1'b0;
  endfunction

  function automatic bit cpha_of(input int ch);
    return (ch < 4) ? bit'(ch % 2) : 1'b0;
  endfunction

  task automatic ss_low(input int ch);
    ss[ch] = 1'b0;
    clks(10);
  endtask

  task automatic ss_high(input int ch);
    ss[ch] = 1'b1;
    clks(10);
  endtask

  // Host side: SCK half period of 8 clk; MISO captured just before the sampling edge.
  task automatic spi_frame(input int ch, input int nbits, input logic [63:0] dout,
                           output logic [63:0] din);
    bit cp, ph, msb;
    int pos;
    cp  = cpol_of(ch);
    ph  = cpha_of(ch);
    msb = (ch < 4);
    din = '0;
    for (int i = 0; i < nbits; i++) begin
      pos = msb ? nbits - 1 - i : i;
      if (!ph) begin
        mosi[ch] = dout[pos];
        clks(8);
        din[pos] = miso[ch];
        sck[ch]  = ~cp;
        clks(8);
        sck[ch]  = cp;
      end else begin
        sck[ch]  = ~cp;
        mosi[ch] = dout[pos];
        clks(8);
        din[pos] = miso[ch];
        sck[ch]  = cp;
        clks(8);
      end
    end
    clks(8);
  endtask

  task automatic pop_a();
    rxr_a = 1'b1;
    clks(1);
    rxr_a = 1'b0;
    clks(1);
  endtask

  task automatic pop_m(input int ch);
    rxr_m[ch] = 1'b1;
    clks(1);
    rxr_m[ch] = 1'b0;
    clks(1);
  endtask

  logic [63:0] cap;

  initial begin
    reset = 1'b1;
    sck   = 5'b01100;
    ss    = '1;
    mosi  = '0;
    rxr_m = '0;
    clr_m = '0;
    txd_a = '0;
    txv_a = 1'b0;
    rxr_a = 1'b0;
    clr_a = 1'b0;
    clks(4);
    check("reset_miso", 64'(miso[4]), 64'd1);
    check("reset_tx_ready", 64'(txr_a), 64'd1);
    check("reset_rx_valid", 64'(rxv_a), 64'd0);
    reset = 1'b0;
    clks(4);

    // Mode 0, LSB first, queued payload
    txd_a = 24'hCAFE77;
    txv_a = 1'b1;
    clks(1);
    txv_a = 1'b0;
    check("tx_ready_after_accept", 64'(txr_a), 64'd0);
    ss_low(4);
    spi_frame(4, 32, 64'h0000_0101, cap);
    check("t1_miso_frame", cap, 64'h0000_0000_CAFE_7703);
    check("t1_rx_valid", 64'(rxv_a), 64'd1);
    check("t1_rx_data", 64'(rxd_a), 64'h0000_0101);
    check("t1_tx_ready_back", 64'(txr_a), 64'd1);
    ss_high(4);
    pop_a();
    check("t1_rx_valid_after_pop", 64'(rxv_a), 64'd0);

    // No payload queued: zeros after status 8'h01
    ss_low(4);
    spi_frame(4, 32, 64'h1234_5678, cap);
    ss_high(4);
    check("t5_miso_no_payload", cap, 64'h0000_0000_0000_0001);
    check("t5_rx_data", 64'(rxd_a), 64'h1234_5678);
    pop_a();

    // Abort after 13 bits, then a clean frame
    ss_low(4);
    spi_frame(4, 13, 64'h1FFF, cap);
    ss_high(4);
    check("t4_abort_pulses", 64'(abort_cnt), 64'd1);
    check("t4_rx_valid_after_abort", 64'(rxv_a), 64'd0);
    ss_low(4);
    spi_frame(4, 32, 64'hDEAD_BEEF, cap);
    ss_high(4);
    check("t4_rx_data_after_abort", 64'(rxd_a), 64'hDEAD_BEEF);
    check("t4_no_extra_abort", 64'(abort_cnt), 64'd1);

    // All four modes, MSB first, 16-bit frames
    for (int ch = 0; ch < 4; ch++) begin
      ss_low(ch);
      spi_frame(ch, 16, 64'hA55A, cap);
      ss_high(ch);
      check($sformatf("t2_rx_data_mode%0d", ch), 64'(rxd_m[ch]), 64'hA55A);
      check($sformatf("t2_miso_mode%0d", ch), cap, 64'h0100);
      pop_m(ch);
    end

    // Three back-to-back frames into a depth-2 FIFO
    ss_low(0);
    spi_frame(0, 16, 64'h1111, cap);
    check("t3_miso_f1", cap, 64'h0100);
    spi_frame(0, 16, 64'h2222, cap);
    check("t3_miso_f2", cap, 64'h1100);
    spi_frame(0, 16, 64'h3333, cap);
    check("t3_miso_f3", cap, 64'h2000);
    check("t3_f3_room_bit", 64'(cap[8]), 64'd0);
    ss_high(0);
    check("t3_overflow", 64'(ovf_m[0]), 64'd1);
    check("t3_head1", 64'(rxd_m[0]), 64'h1111);
    pop_m(0);
    check("t3_head2", 64'(rxd_m[0]), 64'h2222);
    pop_m(0);
    check("t3_empty", 64'(rxv_m[0]), 64'd0);
    clr_m[0] = 1'b1;
    clks(1);
    clr_m[0] = 1'b0;
    clks(1);
    check("t3_ovf_cleared", 64'(ovf_m[0]), 64'd0);

    // Reset mid-frame with a word stored and a payload pending
    ss_low(4);
    txd_a = 24'h123456;
    txv_a = 1'b1;
    clks(1);
    txv_a = 1'b0;
    spi_frame(4, 10, 64'h3FF, cap);
    check("pre_reset_rx_valid", 64'(rxv_a), 64'd1);
    reset = 1'b1;
    clks(1);
    check("rst_miso", 64'(miso[4]), 64'd1);
    check("rst_tx_ready", 64'(txr_a), 64'd1);
    check("rst_rx_valid", 64'(rxv_a), 64'd0);
    check("rst_rx_data", 64'(rxd_a), 64'd0);
    check("rst_overflow", 64'(ovf_a), 64'd0);
    check("rst_frame_abort", 64'(abt_a), 64'd0);
    reset = 1'b0;
    clks(10);
    ss_high(4);
    check("rst_no_abort", 64'(abort_cnt), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
